// File: rtl/tlb_port_arbiter_pkg.sv
// rtl/tlb_port_arbiter_pkg.sv - shared encodings for the TLB port arbiter
// Purpose: requester source codes, arbiter state encoding, default op width,
//          and a one-hot grant to source-code helper.
// Ports:   none (package).
package tlb_port_arbiter_pkg;

  localparam int OPBITS_DEF = 4;

  localparam logic [1:0] SRC_I  = 2'd0;
  localparam logic [1:0] SRC_D  = 2'd1;
  localparam logic [1:0] SRC_OP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Grant vectors are indexed by source code; the picker guarantees one-hot.
  function automatic logic [1:0] grant_to_src(input logic [2:0] grant);
    logic [1:0] src;
    src = SRC_I;
    if (grant[SRC_OP]) begin
      src = SRC_OP;
    end else if (grant[SRC_D]) begin
      src = SRC_D;
    end
    return src;
  endfunction

endpackage

// File: rtl/tlb_arb_pick.sv
// rtl/tlb_arb_pick.sv - fixed-priority requester picker with fetch starvation override
// Purpose: combinational op > data > fetch selection; a starving fetch wins outright.
// Ports:
//   i_req_i, d_req_i, op_req_i : pending requests
//   starve_hit_i               : fetch has lost too often and is still requesting
//   grant_o[2:0]               : one-hot grant indexed by source code (all zero if idle)
module tlb_arb_pick
  import tlb_port_arbiter_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       op_req_i,
  input  logic       starve_hit_i,
  output logic [2:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (starve_hit_i) begin
      grant_o[SRC_I] = 1'b1;
    end else if (op_req_i) begin
      grant_o[SRC_OP] = 1'b1;
    end else if (d_req_i) begin
      grant_o[SRC_D] = 1'b1;
    end else if (i_req_i) begin
      grant_o[SRC_I] = 1'b1;
    end
  end

endmodule

// File: rtl/tlb_port_arbiter.sv
// rtl/tlb_port_arbiter.sv - serialises fetch/data/maintenance requests onto one TLB engine
// Purpose: one outstanding engine transaction at a time, tagged with its owner;
//          the registered result is returned only to that owner.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   i_req/i_vaddr/i_cacop/i_cancel    : fetch request side; i_recv, i_finish pulses
//   d_req/d_wr/d_vaddr                : data request side;  d_recv, d_finish pulses
//   op_req/op_code/op_vaddr           : maintenance side;   op_recv, op_finish pulses
//   eng_req/eng_src/eng_vaddr/eng_wr/eng_cacop/eng_op : engine command (grant cycle)
//   eng_finish/eng_hit/eng_uncached/eng_paddr/eng_exccode : engine result
//   rsp_hit/rsp_uncached/rsp_paddr/rsp_exccode : registered result, held until next result
module tlb_port_arbiter
  import tlb_port_arbiter_pkg::*;
#(
  parameter int GRLEN        = 32,
  parameter int PABITS       = 32,
  parameter int OPBITS       = OPBITS_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [GRLEN-1:0]  i_vaddr,
  input  logic              i_cacop,
  input  logic              i_cancel,
  output logic              i_recv,
  output logic              i_finish,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [GRLEN-1:0]  d_vaddr,
  output logic              d_recv,
  output logic              d_finish,
  input  logic              op_req,
  input  logic [OPBITS-1:0] op_code,
  input  logic [GRLEN-1:0]  op_vaddr,
  output logic              op_recv,
  output logic              op_finish,
  output logic              eng_req,
  output logic [1:0]        eng_src,
  output logic [GRLEN-1:0]  eng_vaddr,
  output logic              eng_wr,
  output logic              eng_cacop,
  output logic [OPBITS-1:0] eng_op,
  input  logic              eng_finish,
  input  logic              eng_hit,
  input  logic              eng_uncached,
  input  logic [PABITS-1:0] eng_paddr,
  input  logic [5:0]        eng_exccode,
  output logic              rsp_hit,
  output logic              rsp_uncached,
  output logic [PABITS-1:0] rsp_paddr,
  output logic [5:0]        rsp_exccode
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        cancel_q, cancel_d;
  logic [7:0]  starve_q, starve_d;
  logic [2:0]  grant;
  logic [1:0]  win_src;
  logic        starve_hit;

  assign starve_hit = i_req && (starve_q == LIMIT);
  assign win_src    = grant_to_src(grant);

  tlb_arb_pick u_pick (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .op_req_i     (op_req),
    .starve_hit_i (starve_hit),
    .grant_o      (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= SRC_I;
      cancel_q     <= 1'b0;
      starve_q     <= '0;
      rsp_hit      <= 1'b0;
      rsp_uncached <= 1'b0;
      rsp_paddr    <= '0;
      rsp_exccode  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cancel_q <= cancel_d;
      starve_q <= starve_d;
      if (state_q == ST_BUSY && eng_finish) begin
        rsp_hit      <= eng_hit;
        rsp_uncached <= eng_uncached;
        rsp_paddr    <= eng_paddr;
        rsp_exccode  <= eng_exccode;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cancel_d  = cancel_q;
    starve_d  = starve_q;
    i_recv    = 1'b0;
    d_recv    = 1'b0;
    op_recv   = 1'b0;
    i_finish  = 1'b0;
    d_finish  = 1'b0;
    op_finish = 1'b0;
    eng_req   = 1'b0;
    eng_src   = SRC_I;
    eng_vaddr = '0;
    eng_wr    = 1'b0;
    eng_cacop = 1'b0;
    eng_op    = '0;

    // Combinational outputs are forced quiet while reset is held so that a
    // reset landing in BUSY/RESP cannot leak a stray recv/finish pulse.
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          cancel_d = 1'b0;
          if (|grant) begin
            eng_req = 1'b1;
            eng_src = win_src;
            owner_d = win_src;
            state_d = ST_BUSY;
            case (win_src)
              SRC_OP: begin
                op_recv   = 1'b1;
                eng_vaddr = op_vaddr;
                eng_op    = op_code;
              end
              SRC_D: begin
                d_recv    = 1'b1;
                eng_vaddr = d_vaddr;
                eng_wr    = d_wr;
              end
              default: begin
                i_recv    = 1'b1;
                eng_vaddr = i_vaddr;
                eng_cacop = i_cacop;
              end
            endcase
            // Count only grants that fetch lost while it was waiting.
            if (grant[SRC_I]) begin
              starve_d = '0;
            end else if (i_req && starve_q != LIMIT) begin
              starve_d = starve_q + 8'd1;
            end
          end
        end
        ST_BUSY: begin
          if (i_cancel && owner_q == SRC_I) cancel_d = 1'b1;
          if (eng_finish) state_d = ST_RESP;
        end
        ST_RESP: begin
          op_finish = (owner_q == SRC_OP);
          d_finish  = (owner_q == SRC_D);
          // A cancel arriving in the finish cycle itself also suppresses it.
          i_finish  = (owner_q == SRC_I) && !cancel_q && !i_cancel;
          cancel_d  = 1'b0;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (!i_req) starve_d = '0;
    end
  end

  a_finish_only_busy: assert property (@(posedge clk) disable iff (reset)
    eng_finish |-> (state_q == ST_BUSY));

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// tb/tb_tlb_port_arbiter.sv - directed self-checking bench for tlb_port_arbiter
module tb_tlb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_cacop, i_cancel, i_recv, i_finish;
  logic [31:0] i_vaddr;
  logic        d_req, d_wr, d_recv, d_finish;
  logic [31:0] d_vaddr;
  logic        op_req, op_recv, op_finish;
  logic [3:0]  op_code;
  logic [31:0] op_vaddr;
  logic        eng_req, eng_wr, eng_cacop;
  logic [1:0]  eng_src;
  logic [31:0] eng_vaddr;
  logic [3:0]  eng_op;
  logic        eng_finish, eng_hit, eng_uncached;
  logic [31:0] eng_paddr;
  logic [5:0]  eng_exccode;
  logic        rsp_hit, rsp_uncached;
  logic [31:0] rsp_paddr;
  logic [5:0]  rsp_exccode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlb_port_arbiter #(.GRLEN(32), .PABITS(32), .OPBITS(4), .STARVE_LIMIT(8)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_cacop(i_cacop), .i_cancel(i_cancel),
    .i_recv(i_recv), .i_finish(i_finish),
    .d_req(d_req), .d_wr(d_wr), .d_vaddr(d_vaddr), .d_recv(d_recv), .d_finish(d_finish),
    .op_req(op_req), .op_code(op_code), .op_vaddr(op_vaddr),
    .op_recv(op_recv), .op_finish(op_finish),
    .eng_req(eng_req), .eng_src(eng_src), .eng_vaddr(eng_vaddr), .eng_wr(eng_wr),
    .eng_cacop(eng_cacop), .eng_op(eng_op),
    .eng_finish(eng_finish), .eng_hit(eng_hit), .eng_uncached(eng_uncached),
    .eng_paddr(eng_paddr), .eng_exccode(eng_exccode),
    .rsp_hit(rsp_hit), .rsp_uncached(rsp_uncached), .rsp_paddr(rsp_paddr),
    .rsp_exccode(rsp_exccode)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Entered in the grant cycle. Drops the accepted request(s) in cycle 1,
  // optionally cancels in BUSY, returns the engine result at cycle lat and
  // leaves the bench in the RESP cycle with outputs settled.
  task automatic run_engine(input logic [2:0] drop, input logic cxl, input int lat,
                            input logic [31:0] pa, input logic hit, input logic unc,
                            input logic [5:0] exc);
    next();
    if (drop[0]) i_req  = 1'b0;
    if (drop[1]) d_req  = 1'b0;
    if (drop[2]) op_req = 1'b0;
    i_cancel = cxl;
    for (int k = 1; k < lat; k++) next();
    eng_finish = 1'b1; eng_paddr = pa; eng_hit = hit; eng_uncached = unc; eng_exccode = exc;
    next();
    eng_finish = 1'b0;
    i_cancel   = 1'b0;
    #2;
  endtask

  task automatic check_finishes(input string tag, input logic [2:0] exp_iod);
    check({tag, "_i_finish"},  i_finish,  exp_iod[0]);
    check({tag, "_d_finish"},  d_finish,  exp_iod[1]);
    check({tag, "_op_finish"}, op_finish, exp_iod[2]);
  endtask

  initial begin
    reset = 1'b1;
    i_req = 0; i_cacop = 0; i_cancel = 0; i_vaddr = '0;
    d_req = 0; d_wr = 0; d_vaddr = '0;
    op_req = 0; op_code = '0; op_vaddr = '0;
    eng_finish = 0; eng_hit = 0; eng_uncached = 0; eng_paddr = '0; eng_exccode = '0;
    next(); next();
    reset = 1'b0;
    next(); #2;
    check("rst_eng_req", eng_req, 1'b0);
    check("rst_recvs", {i_recv, d_recv, op_recv}, 3'b000);
    check_finishes("rst", 3'b000);
    check("rst_rsp", {rsp_hit, rsp_uncached, rsp_paddr, rsp_exccode}, '0);

    // Single fetch, engine latency 2
    next();
    i_req = 1'b1; i_vaddr = 32'h1c00_0000;
    #2;
    check("f_eng_req", eng_req, 1'b1);
    check("f_i_recv", i_recv, 1'b1);
    check("f_eng_src", eng_src, 2'd0);
    check("f_eng_vaddr", eng_vaddr, 32'h1c00_0000);
    run_engine(3'b001, 1'b0, 2, 32'h1c00_0000, 1'b1, 1'b0, 6'h0);
    check_finishes("f", 3'b001);
    check("f_rsp_paddr", rsp_paddr, 32'h1c00_0000);
    check("f_rsp_hit", rsp_hit, 1'b1);
    next(); #2;
    check("f_idle_after", {i_finish, eng_req}, 2'b00);

    // All three together: op, data, fetch in that order
    op_req = 1; op_code = 4'h5; op_vaddr = 32'h0000_00aa;
    d_req = 1;  d_wr = 0;       d_vaddr = 32'h0000_0bbb;
    i_req = 1;  i_vaddr = 32'h0000_0ccc;
    #2;
    check("p0_eng_src", eng_src, 2'd2);
    check("p0_op_recv", {op_recv, d_recv, i_recv}, 3'b100);
    check("p0_eng_op", eng_op, 4'h5);
    check("p0_eng_vaddr", eng_vaddr, 32'h0000_00aa);
    run_engine(3'b100, 1'b0, 1, 32'h1111, 1'b1, 1'b0, 6'h0);
    check_finishes("p0", 3'b100);
    next(); #2;
    check("p1_eng_src", eng_src, 2'd1);
    check("p1_d_recv", {op_recv, d_recv, i_recv}, 3'b010);
    check("p1_eng_op", eng_op, 4'h0);
    run_engine(3'b010, 1'b0, 1, 32'h2222, 1'b1, 1'b0, 6'h0);
    check_finishes("p1", 3'b010);
    next(); #2;
    check("p2_eng_src", eng_src, 2'd0);
    check("p2_i_recv", {op_recv, d_recv, i_recv}, 3'b001);
    run_engine(3'b001, 1'b0, 1, 32'h3333, 1'b1, 1'b0, 6'h0);
    check_finishes("p2", 3'b001);
    check("p2_rsp_paddr", rsp_paddr, 32'h3333);

    // Starvation: data held, fetch held; 9th grant goes to fetch, 10th back to data
    for (int g = 0; g < 10; g++) begin
      next();
      d_req = 1'b1; i_req = 1'b1; d_vaddr = 32'h4000; i_vaddr = 32'h5000;
      #2;
      check($sformatf("st%0d_eng_src", g), eng_src, (g == 8) ? 2'd0 : 2'd1);
      run_engine(3'b000, 1'b0, 1, 32'h6000 + g, 1'b1, 1'b0, 6'h0);
      check_finishes($sformatf("st%0d", g), (g == 8) ? 3'b001 : 3'b010);
    end
    d_req = 1'b0; i_req = 1'b0;

    // Fetch cancelled in BUSY: engine completes, no i_finish
    next();
    i_req = 1'b1; i_vaddr = 32'h7000;
    #2;
    check("c_i_recv", i_recv, 1'b1);
    run_engine(3'b001, 1'b1, 2, 32'h7777, 1'b0, 1'b0, 6'h3);
    check_finishes("c", 3'b000);
    check("c_rsp_exccode", rsp_exccode, 6'h3);

    // Data store after cancel: uncached result
    next();
    d_req = 1'b1; d_wr = 1'b1; d_vaddr = 32'h8000;
    #2;
    check("d_d_recv", d_recv, 1'b1);
    check("d_eng_wr_cacop", {eng_wr, eng_cacop}, 2'b10);
    run_engine(3'b010, 1'b0, 1, 32'h8888, 1'b1, 1'b1, 6'h0);
    check_finishes("d", 3'b010);
    check("d_rsp_unc_exc", {rsp_uncached, rsp_exccode}, {1'b1, 6'h0});
    d_wr = 1'b0;

    // Cacop fetch with i_cancel in IDLE (no effect)
    next();
    i_req = 1'b1; i_cacop = 1'b1; i_cancel = 1'b1; i_vaddr = 32'h9000;
    #2;
    check("k_eng_wr_cacop", {eng_wr, eng_cacop}, 2'b01);
    run_engine(3'b001, 1'b0, 1, 32'h9999, 1'b1, 1'b0, 6'h0);
    check_finishes("k", 3'b001);
    i_cacop = 1'b0;

    // Reset mid-BUSY: transaction dropped, stray engine finish ignored
    next();
    i_req = 1'b1; i_vaddr = 32'ha000;
    #2;
    check("r_i_recv", i_recv, 1'b1);
    next();
    i_req = 1'b0; reset = 1'b1;
    next();
    eng_finish = 1'b1; eng_paddr = 32'hdead; eng_hit = 1'b1; eng_exccode = 6'h3f;
    #2;
    check("r_outs_in_reset", {eng_req, i_recv, d_recv, op_recv, i_finish, d_finish, op_finish}, '0);
    next();
    reset = 1'b0; eng_finish = 1'b0;
    #2;
    check("r_rsp_cleared", {rsp_hit, rsp_uncached, rsp_paddr, rsp_exccode}, '0);
    check_finishes("r0", 3'b000);
    next(); #2;
    check_finishes("r1", 3'b000);
    check("r_rsp_held", rsp_paddr, 32'h0);
    d_req = 1'b1; d_vaddr = 32'hb000;
    #2;
    check("r_idle_accept", {d_recv, eng_req, eng_src}, {1'b1, 1'b1, 2'd1});
    run_engine(3'b010, 1'b0, 1, 32'hbbbb, 1'b1, 1'b0, 6'h0);
    check_finishes("r2", 3'b010);
    check("r2_rsp_paddr", rsp_paddr, 32'hbbbb);

    next();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_port_arbiter.md
Name: tlb_port_arbiter

Overview:
- Shares the single-port TLB lookup engine inside the TLB wrapper among three requesters: instruction fetch translation, data access translation, and CSR-driven TLB maintenance ops (tlbsrch/tlbrd/tlbwr/tlbfill/invtlb).
- Sits between cpu7 and the TLB lookup engine.
- Serialises requests and tags the one outstanding request with its owner. Routes the engine result back to that owner only.
- Uses fixed priority with an anti-starvation override for instruction fetch.

Parameters:
- GRLEN, 32, virtual address / data width
- PABITS, 32, physical address width
- OPBITS, 4, TLB maintenance op code width
- STARVE_LIMIT, 8, consecutive cycles a pending fetch request may lose arbitration before it is forced to win (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  fetch translation request (level, held until i_recv)
- i_vaddr  in  GRLEN  fetch virtual address
- i_cacop  in  1  fetch-side cacop translation
- i_cancel  in  1  fetch flush; discard the outstanding fetch result
- i_recv  out  1  fetch request accepted (1-cycle pulse)
- i_finish  out  1  fetch result valid (1-cycle pulse)
- d_req  in  1  data translation request
- d_wr  in  1  data store
- d_vaddr  in  GRLEN  data virtual address
- d_recv  out  1  data request accepted
- d_finish  out  1  data result valid
- op_req  in  1  maintenance op request
- op_code  in  OPBITS  maintenance op
- op_vaddr  in  GRLEN  invtlb address/asid operand
- op_recv  out  1  op accepted
- op_finish  out  1  op complete
- eng_req  out  1  engine request (1-cycle pulse)
- eng_src  out  2  0 = fetch, 1 = data, 2 = op
- eng_vaddr  out  GRLEN  selected address
- eng_wr  out  1  store flag (data only, else 0)
- eng_cacop  out  1  cacop flag (fetch only, else 0)
- eng_op  out  OPBITS  op code (op only, else 0)
- eng_finish  in  1  engine done (1-cycle pulse, at least 1 cycle after eng_req)
- eng_hit, eng_uncached  in  1 each
- eng_paddr  in  PABITS
- eng_exccode  in  6
- rsp_hit, rsp_uncached  out  1 each  registered result, shared by all requesters
- rsp_paddr  out  PABITS
- rsp_exccode  out  6

Behaviour:
- Reset: all outputs 0; state IDLE; starve counter 0; cancel flag 0.
- States:
  - IDLE: if any request is pending, grant a winner; pulse eng_req and the winner's *_recv in the same cycle, with eng_* fields driven combinationally from the winner; latch the owner; go to BUSY.
  - BUSY: wait for eng_finish. On eng_finish, register rsp_* and go to RESP.
  - RESP (1 cycle): pulse the owner's *_finish with rsp_* valid (the fetch finish is suppressed if cancelled); return to IDLE.
  - Request-to-finish latency is therefore engine latency + 1. Back-to-back throughput is one request per engine latency + 2 cycles.
- Priority: op > data > fetch.
  - Exception: when starve_cnt == STARVE_LIMIT and i_req is set, fetch wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) on every IDLE grant that goes to another requester while i_req is high.
  - starve_cnt clears when fetch is granted or when i_req is low.
- Cancel:
  - i_cancel in BUSY or RESP with owner = fetch sets the cancel flag; that fetch's i_finish is suppressed. The engine transaction still completes.
  - i_cancel in IDLE has no effect.
  - The cancel flag clears on entry to IDLE.
- Simultaneous events:
  - eng_finish in RESP or IDLE is illegal and ignored (assertion).
  - A request rising in the same cycle as RESP waits for IDLE.
- rsp_* hold their value until the next eng_finish.
- Synchronous reset mid-BUSY: drops the transaction with no finish pulse; the engine is reset by the same signal.

Decomposition:
- Shared package/header: source encodings (SRC_I = 0, SRC_D = 1, SRC_OP = 2), state encodings, OPBITS.
- One sub-module tlb_arb_pick: combinational priority + starvation-override selector. Inputs: three requests + starve_hit. Output: one-hot grant.

Test Plan:
- Single fetch, i_vaddr = 0x1c000000, engine finishes 2 cycles after eng_req with paddr 0x1c000000, hit = 1 -> i_recv at cycle 0, eng_src = 0, i_finish at cycle 3 with rsp_paddr = 0x1c000000; d_finish and op_finish stay 0.
- op_req, d_req and i_req asserted together, engine latency 1 -> grant order op, data, fetch; eng_src sequence 2, 1, 0; each finish fires only for its owner.
- d_req held continuously plus i_req high, STARVE_LIMIT = 8 -> the 9th grant goes to fetch (eng_src = 0); starve_cnt returns to 0.
- Fetch granted, i_cancel pulsed in BUSY, engine returns exccode 0x3 -> no i_finish; rsp_exccode = 0x3; next IDLE accepts a new request normally.
- d_req with d_wr = 1, engine returns uncached = 1, exccode = 0 -> eng_wr = 1, eng_cacop = 0, d_finish with rsp_uncached = 1.
- reset asserted during BUSY -> next cycle all outputs 0, state IDLE; a later eng_finish pulse produces no *_finish.
